// File: rtl/ahbl_uart_tx_if.sv
// ahbl_uart_tx_if
//   AHB-Lite bus signals shared between a master (the SoC address splitter
//   or a testbench) and the ahbl_uart_tx slave.
//   master modport: drives HADDR/HTRANS/HSIZE/HWRITE/HREADY/HSEL/HWDATA,
//                   receives HREADYOUT/HRDATA.
//   slave modport : the reverse direction.
interface ahbl_uart_tx_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HADDR, HTRANS, HSIZE, HWRITE, HREADY, HSEL, HWDATA,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HWRITE, HREADY, HSEL, HWDATA,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahbl_uart_tx.sv
// ahbl_uart_tx
//   AHB-Lite slave UART transmitter. Bytes written to DATA are buffered in a
//   FIFO_DEPTH-entry FIFO and sent as 8N1 frames on TX, one bit per
//   BAUDDIV+1 HCLK cycles.
//   Register map (HADDR[3:2]):
//     0x0 DATA    W: push HWDATA[7:0]; reads 0
//     0x4 STATUS  R: [0] busy [1] full [2] empty [3] overflow [7:4] count; W1C [3]
//     0x8 CTRL    RW: [0] enable, [1] irq_en (only with UART_IRQ_EN)
//     0xC BAUDDIV RW: [15:0]
//   Ports:
//     HCLK, HRESETn : clock, asynchronous active-low reset
//     bus           : AHB-Lite slave modport (ahbl_uart_tx_if.slave)
//     TX            : serial output, idle high
//     IRQ           : interrupt, present only when UART_IRQ_EN is defined
//   Optional feature macro: UART_IRQ_EN.
module ahbl_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned BAUDDIV_RST = 433
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  ahbl_uart_tx_if.slave bus,
  output logic          TX
`ifdef UART_IRQ_EN
  ,
  output logic          IRQ
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Bus pipeline
  logic        dphase_q;
  logic        dwrite_q;
  logic [1:0]  daddr_q;
  logic        addr_accept_s;
  logic        wr_en_s;
  logic        wr_data_s;
  logic        wr_status_s;
  logic        wr_ctrl_s;
  logic        wr_baud_s;
  logic [31:0] rdata_s;

  // Registers
  logic        ctrl_en_q;
  logic        ctrl_irq_s;
  logic [15:0] bauddiv_q;
  logic        ovf_q;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          drop_s;
  logic          pop_s;
  logic [3:0]    cnt4_s;

  // Transmitter
  state_e      state_q;
  state_e      state_d;
  logic [15:0] baud_cnt_q;
  logic [15:0] baud_cnt_d;
  logic [15:0] period_q;
  logic [15:0] period_d;
  logic [2:0]  bit_idx_q;
  logic [2:0]  bit_idx_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        tx_q;
  logic        tx_d;
  logic        bit_done_s;
  logic        busy_s;

  logic        unused_s;

  assign addr_accept_s = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  // A write lands when its data phase completes, i.e. when the bus is ready.
  assign wr_en_s     = dphase_q & dwrite_q & bus.HREADY;
  assign wr_data_s   = wr_en_s & (daddr_q == 2'd0);
  assign wr_status_s = wr_en_s & (daddr_q == 2'd1);
  assign wr_ctrl_s   = wr_en_s & (daddr_q == 2'd2);
  assign wr_baud_s   = wr_en_s & (daddr_q == 2'd3);

  assign unused_s = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0],
                      bus.HSIZE, bus.HWDATA[31:16]};

  // Address-phase capture; held while another slave stalls the bus
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dphase_q <= 1'b0;
      dwrite_q <= 1'b0;
      daddr_q  <= 2'd0;
    end else if (bus.HREADY) begin
      dphase_q <= addr_accept_s;
      dwrite_q <= bus.HWRITE;
      daddr_q  <= bus.HADDR[3:2];
    end
  end

  // Control, baud divisor and sticky overflow registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_en_q <= 1'b0;
      bauddiv_q <= 16'(BAUDDIV_RST);
      ovf_q     <= 1'b0;
    end else begin
      if (wr_ctrl_s) ctrl_en_q <= bus.HWDATA[0];
      if (wr_baud_s) bauddiv_q <= bus.HWDATA[15:0];
      if (drop_s) begin
        ovf_q <= 1'b1;
      end else if (wr_status_s && bus.HWDATA[3]) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef UART_IRQ_EN
  logic ctrl_irq_q;
  logic irq_q;

  // Interrupt enable bit
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ctrl_irq_q <= 1'b0;
    else if (wr_ctrl_s) ctrl_irq_q <= bus.HWDATA[1];
  end

  // Interrupt line, registered so it follows its cause by one cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) irq_q <= 1'b0;
    else irq_q <= ctrl_irq_q & (empty_s | ovf_q);
  end

  assign ctrl_irq_s = ctrl_irq_q;
  assign IRQ        = irq_q;
`else
  assign ctrl_irq_s = 1'b0;
`endif

  // FIFO status and push/pop qualification
  assign full_s  = (count_q == CW'(FIFO_DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});
  assign push_s  = wr_data_s & ~full_s;
  assign drop_s  = wr_data_s & full_s;
  assign cnt4_s  = 4'(count_q);

  // FIFO occupancy next-state; simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; reset flushes the FIFO
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage (no reset needed, guarded by the pointers)
  always_ff @(posedge HCLK) begin
    if (push_s) mem_q[wr_ptr_q] <= bus.HWDATA[7:0];
  end

  assign bit_done_s = (baud_cnt_q == period_q);
  assign busy_s     = (state_q != S_IDLE);

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl_en_q && !empty_s) state_d = S_START;
        else state_d = S_IDLE;
      end
      S_START: begin
        if (bit_done_s) state_d = S_DATA;
        else state_d = S_START;
      end
      S_DATA: begin
        if (bit_done_s && (bit_idx_q == 3'd7)) state_d = S_STOP;
        else state_d = S_DATA;
      end
      S_STOP: begin
        if (bit_done_s) state_d = S_IDLE;
        else state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: pop strobe, bit timing, shifter and next TX level.
  // The bit period is sampled at each bit start so a BAUDDIV write only
  // affects the following bit.
  always_comb begin
    pop_s      = 1'b0;
    baud_cnt_d = baud_cnt_q + 16'd1;
    period_d   = period_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = 16'd0;
        if (state_d == S_START) begin
          pop_s    = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          period_d = bauddiv_q;
        end else begin
          pop_s    = 1'b0;
        end
      end
      S_START: begin
        if (bit_done_s) begin
          baud_cnt_d = 16'd0;
          period_d   = bauddiv_q;
          bit_idx_d  = 3'd0;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done_s) begin
          baud_cnt_d = 16'd0;
          period_d   = bauddiv_q;
          bit_idx_d  = bit_idx_q + 3'd1;
          shift_d    = {1'b0, shift_q[7:1]};
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done_s) baud_cnt_d = 16'd0;
        else baud_cnt_d = baud_cnt_q + 16'd1;
      end
      default: baud_cnt_d = 16'd0;
    endcase
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Transmitter datapath registers; TX is registered and idles high
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      baud_cnt_q <= 16'd0;
      period_q   <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      period_q   <= period_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // Read data mux, driven only during a read data phase
  always_comb begin
    rdata_s = 32'd0;
    if (dphase_q && !dwrite_q) begin
      case (daddr_q)
        2'd0:    rdata_s = 32'd0;
        2'd1:    rdata_s = {24'd0, cnt4_s, ovf_q, empty_s, full_s, busy_s};
        2'd2:    rdata_s = {30'd0, ctrl_irq_s, ctrl_en_q};
        2'd3:    rdata_s = {16'd0, bauddiv_q};
        default: rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign bus.HRDATA    = rdata_s;
  assign bus.HREADYOUT = 1'b1;
  assign TX            = tx_q;

endmodule

// File: tb/tb_ahbl_uart_tx.sv
// tb_ahbl_uart_tx
//   Randomized self-checking bench for ahbl_uart_tx. A queue holds the bytes
//   the FIFO should contain; the TX waveform and STATUS word for every cycle
//   after an enabling edge are derived arithmetically from frame length and
//   bit position. Build with UART_IRQ_EN defined to include the IRQ checks.
module tb_ahbl_uart_tx;

  logic HCLK;
  logic HRESETn;
  logic TX;
`ifdef UART_IRQ_EN
  logic IRQ;
  localparam logic [31:0] CTRL_MASK = 32'h3;
`else
  localparam logic [31:0] CTRL_MASK = 32'h1;
`endif

  ahbl_uart_tx_if bus ();

  ahbl_uart_tx #(.FIFO_DEPTH(8), .BAUDDIV_RST(433)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus),
    .TX      (TX)
`ifdef UART_IRQ_EN
    ,
    .IRQ     (IRQ)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] fq[$];
  logic       ovf_m = 1'b0;
  int         t0 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status(input int cnt, input logic busy);
    logic [3:0] c;
    c = cnt[3:0];
    return {24'd0, c, ovf_m, (cnt == 0), (cnt == 8), busy};
  endfunction

  task automatic idle_bus();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h8000_0000;
  endtask

  task automatic addr_phase(input logic [3:0] a, input logic wr);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
    bus.HADDR  = {28'h8000000, a};
  endtask

  // Returns at edge+1 right after the write's data phase completed.
  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    @(posedge HCLK); #1;
    idle_bus();
    bus.HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0);
    @(posedge HCLK); #1;
    idle_bus();
    d = bus.HRDATA;
    @(posedge HCLK); #1;
  endtask

  // Write followed by a read whose address phase overlaps the write data phase.
  task automatic wr_rd(input logic [3:0] a, input logic [31:0] d, output logic [31:0] r);
    addr_phase(a, 1'b1);
    @(posedge HCLK); #1;
    bus.HWDATA = d;
    addr_phase(a, 1'b0);
    @(posedge HCLK); #1;
    idle_bus();
    r = bus.HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus_wr(4'h0, {24'd0, b});
    if (fq.size() < 8) fq.push_back(b);
    else ovf_m = 1'b1;
  endtask

  task automatic retire(input int nf);
    for (int i = 0; i < nf; i++) void'(fq.pop_front());
  endtask

  // Reads STATUS every cycle and checks TX/STATUS against the frame schedule
  // measured from reference edge t0, with nf frames sent back to back.
  task automatic watch(input int until_k, input int nf, input int bd);
    int k, per, flen, f, off, bit_i, started, cnt;
    logic exp_tx, exp_busy;
    flen = 10 * (bd + 1);
    per  = flen + 1;
    addr_phase(4'h4, 1'b0);
    while ((cyc - t0) < until_k) begin
      @(posedge HCLK); #1;
      k   = cyc - t0;
      f   = (k - 1) / per;
      off = (k - 1) % per;
      if (f < nf && off < flen) begin
        exp_busy = 1'b1;
        bit_i    = off / (bd + 1);
        if (bit_i == 0) exp_tx = 1'b0;
        else if (bit_i == 9) exp_tx = 1'b1;
        else exp_tx = fq[f][bit_i-1];
      end else begin
        exp_busy = 1'b0;
        exp_tx   = 1'b1;
      end
      started = (f + 1 < nf) ? f + 1 : nf;
      cnt     = fq.size() - started;
      chk("tx", {31'd0, TX}, {31'd0, exp_tx});
      chk("status", bus.HRDATA, exp_status(cnt, exp_busy));
    end
    idle_bus();
  endtask

  logic [31:0] rd;
  logic [31:0] d;
  int bd, n, nf, per;

  initial begin
    HRESETn    = 1'b0;
    idle_bus();
    bus.HREADY = 1'b1;
    bus.HSIZE  = 3'b010;
    bus.HWDATA = 32'd0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Reset state
    chk("rst_tx", {31'd0, TX}, 32'd1);
    chk("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
    chk("rst_hrdata", bus.HRDATA, 32'd0);
`ifdef UART_IRQ_EN
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
`endif
    bus_rd(4'h4, rd); chk("rst_status", rd, 32'h0000_0004);
    bus_rd(4'hC, rd); chk("rst_bauddiv", rd, 32'd433);
    bus_rd(4'h8, rd); chk("rst_ctrl", rd, 32'd0);
    bus_rd(4'h0, rd); chk("data_reads_0", rd, 32'd0);

    // Register write visible in the very next data phase
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      wr_rd(4'hC, d, rd); chk("bauddiv_rb", rd, d & 32'h0000_FFFF);
      d = $urandom;
      wr_rd(4'h8, d, rd); chk("ctrl_rb", rd, d & CTRL_MASK);
    end
    bus_wr(4'h8, 32'd0);

    // Single 0x55 frame at 4 cycles per bit, enabled before the push
    bus_wr(4'hC, 32'd3);
    bus_wr(4'h8, 32'd1);
    push(8'h55);
    t0 = cyc;
    chk("tx_before_start", {31'd0, TX}, 32'd1);
    watch(45, 1, 3);
    retire(1);
    bus_wr(4'h8, 32'd0);

    // Overflow: nine pushes while disabled, then W1C of the sticky bit
    for (int i = 0; i < 9; i++) push(8'($urandom));
    bus_rd(4'h4, rd); chk("ovf_status", rd, 32'h0000_008A);
    bus_wr(4'h4, 32'h8);
    ovf_m = 1'b0;
    bus_rd(4'h4, rd); chk("ovf_cleared", rd, 32'h0000_0082);

    // Eight queued bytes drained at one cycle per bit
    bus_wr(4'hC, 32'd0);
    bus_wr(4'h8, 32'd1);
    t0 = cyc;
    chk("tx_k0", {31'd0, TX}, 32'd1);
    watch(8 * 11 + 3, 8, 0);
    retire(8);
    bus_wr(4'h8, 32'd0);

    // Randomized bursts at random bit rates
    for (int it = 0; it < 6; it++) begin
      bd = $urandom_range(0, 3);
      n  = $urandom_range(1, 10);
      bus_wr(4'hC, bd);
      for (int i = 0; i < n; i++) push(8'($urandom));
      bus_rd(4'h4, rd); chk("rand_queued", rd, exp_status(fq.size(), 1'b0));
      if (ovf_m) begin
        bus_wr(4'h4, 32'h8);
        ovf_m = 1'b0;
      end
      nf = fq.size();
      bus_wr(4'h8, 32'd1);
      t0 = cyc;
      watch(nf * (10 * (bd + 1) + 1) + 3, nf, bd);
      retire(nf);
      bus_wr(4'h8, 32'd0);
    end

    // Interrupt enable with empty FIFO, then a push while disabled
`ifdef UART_IRQ_EN
    bus_wr(4'h8, 32'd3);
    chk("irq_lag", {31'd0, IRQ}, 32'd0);
    @(posedge HCLK); #1;
    chk("irq_set", {31'd0, IRQ}, 32'd1);
    bus_wr(4'h8, 32'd2);
`endif
    push(8'hA3);
`ifdef UART_IRQ_EN
    chk("irq_hold", {31'd0, IRQ}, 32'd1);
    @(posedge HCLK); #1;
    chk("irq_clear", {31'd0, IRQ}, 32'd0);
    bus_wr(4'h8, 32'd0);
`endif

    // Enable cleared mid-frame of 0xA3 with two more queued
    push(8'($urandom));
    push(8'($urandom));
    bd  = $urandom_range(2, 4);
    per = 10 * (bd + 1) + 1;
    bus_wr(4'hC, bd);
    bus_wr(4'h8, 32'd1);
    t0 = cyc;
    watch(15, 1, bd);
    bus_wr(4'h8, 32'd0);
    watch(3 * per, 1, bd);
    retire(1);
    bus_rd(4'h4, rd); chk("stop_count", rd, exp_status(2, 1'b0));

    // Reset asserted during a start bit
    bus_wr(4'hC, 32'd3);
    bus_wr(4'h8, 32'd1);
    t0 = cyc;
    watch(3, fq.size(), 3);
    #1 HRESETn = 1'b0;
    #1 chk("async_rst_tx", {31'd0, TX}, 32'd1);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    fq.delete();
    ovf_m = 1'b0;
    bus_rd(4'h4, rd); chk("rst2_status", rd, 32'h0000_0004);
    bus_rd(4'hC, rd); chk("rst2_bauddiv", rd, 32'd433);
    chk("rst2_tx", {31'd0, TX}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ahbl_uart_tx.md
# ahbl_uart_tx

AHB-Lite slave UART transmitter with a small TX FIFO, occupying the previously unused slave-3 slot of the SoC address splitter (0x8000_0000 region). The Hazard2 CPU writes bytes over the bus; the block buffers them and serialises each one as an 8N1 frame on a single TX pin at a programmable bit rate. It gives firmware a console/debug output path alongside the GPIO port.

## Interface
- FIFO_DEPTH, 8, TX FIFO entries (power of two, ≥2)
- BAUDDIV_RST, 433, reset value of BAUDDIV (bit period = BAUDDIV+1 HCLK cycles)
- HCLK  in  1  bus clock, all logic on rising edge
- HRESETn  in  1  reset, asynchronous assert, active-low
- HADDR  in  32  bus address; only [3:2] decoded
- HTRANS  in  2  transfer type; HTRANS[1]=1 means active
- HSIZE  in  3  ignored; all accesses treated as word
- HWRITE  in  1  1=write
- HREADY  in  1  bus-wide ready
- HSEL  in  1  slave select from splitter
- HWDATA  in  32  write data (data phase)
- HREADYOUT  out  1  constant 1 (zero wait states)
- HRDATA  out  32  read data (data phase)
- TX  out  1  serial output, idle high
- IRQ  out  1  only present with UART_IRQ_EN

One clock; reset is asynchronous and active-low (HCLK, HRESETn).

## Operation
- Address phase accepted when HSEL & HREADY & HTRANS[1]; latch HADDR[3:2], HWRITE. Write performed at end of following data phase using HWDATA.
- Registers (offset): 0x0 DATA (W: push HWDATA[7:0]; R: 0); 0x4 STATUS (R: [0] busy, [1] full, [2] empty, [3] overflow sticky, [7:4] count; W1C on [3]); 0x8 CTRL (RW: [0] enable, [1] irq_en); 0xC BAUDDIV (RW [15:0]). Unmapped bits read 0.
- HRDATA driven combinationally from latched offset during data phase; 0 when no read data phase.
- Push when full: byte dropped, overflow set. Push and pop same cycle: both happen, count unchanged.
- FSM: IDLE -> START (enable & !empty: pop byte into shift reg) -> DATA (8 bits, LSB first) -> STOP (TX=1 one bit period) -> IDLE. busy=1 in any state except IDLE.
- Bit counter counts 0..BAUDDIV, then advances bit. BAUDDIV change mid-frame takes effect at next bit boundary. BAUDDIV=0 yields 1 cycle per bit.
- enable cleared mid-frame: current frame completes; no further pops.

## Timing
- Reset: TX=1, HREADYOUT=1, HRDATA=0, FIFO empty, STATUS=0x04, CTRL=0, BAUDDIV=BAUDDIV_RST, FSM=IDLE, IRQ=0.
- Write data phase ends at edge E: FIFO count updated at E; FSM pops at E+1; TX low from E+1.
- Frame length exactly 10×(BAUDDIV+1) cycles; back-to-back frames with FIFO non-empty: next START begins the cycle after STOP ends (no idle gap beyond the pop edge: IDLE lasts 1 cycle).
- Register write visible to read in the very next data phase.
- HRESETn asserted mid-frame: TX returns to 1 immediately (async), FIFO flushed.

## Configuration
- UART_IRQ_EN defined: IRQ port exists; IRQ = CTRL[1] & (empty | overflow), registered, updates one cycle after the cause.
- Undefined: no IRQ port; CTRL[1] not stored, reads 0.

## Test plan
- Reset -> TX=1, STATUS read 0x00000004, BAUDDIV read 433, CTRL read 0.
- BAUDDIV=3, CTRL=1, write 0x55 -> TX: 4 cycles low, bits 1,0,1,0,1,0,1,0 at 4 cycles each, 4 cycles high; busy 1 for 40 cycles.
- CTRL=0, write 9 bytes -> STATUS full=1, count=8, overflow=1; write STATUS 0x8 -> overflow=0, count still 8.
- BAUDDIV=0, enable with 8 bytes queued -> 80 cycles of frames plus one IDLE cycle between each; empty=1 after last pop.
- Clear enable mid-frame of byte 0xA3 with 2 queued -> 0xA3 frame completes, TX stays 1, count=2.
- UART_IRQ_EN, CTRL=3 with FIFO empty -> IRQ=1; push byte while disabled -> IRQ=0 next cycle.
